// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pipe_pkg                                                     |
// | Description : Shared pipeline types and constants for the fetch stage and  |
// |               the decode stage that consumes the IF/ID register.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES       = 32'd4;
  // Instruction fetches are word aligned; the low two address bits are dropped.
  localparam logic [XLEN-1:0] ALIGN_MASK        = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            valid;
  } ifid_t;

  // Builds a valid IF/ID entry; pcPlus4 wraps modulo 2^XLEN.
  function automatic ifid_t ifid_entry(input logic [XLEN-1:0] instr,
                                       input logic [XLEN-1:0] pc);
    ifid_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.pcPlus4 = pc + INSTR_BYTES;
    e.valid   = 1'b1;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_hold_buf                                               |
// | Description : One-entry buffer for an instruction word that returned from  |
// |               imem while IF/ID was held. Flush has priority over capture,  |
// |               capture over release.                                        |
// | Ports       : clk, rst_n (async, active-low), capture/capture_instr/       |
// |               capture_pc (load entry), release_entry (empty it), flush     |
// |               (drop it); valid/instr/pc expose the stored entry.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_hold_buf
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [XLEN-1:0] capture_instr,
  input  logic [XLEN-1:0] capture_pc,
  input  logic            release_entry,
  input  logic            flush,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      instr_d = capture_instr;
      pc_d    = capture_pc;
    end else if (release_entry) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_stage_ctrl                                             |
// | Description : Fetch stage: owns the PC and the IF/ID register, drives a    |
// |               1-cycle-latency synchronous imem, parks a word returning     |
// |               during a stall, and squashes wrong-path fetches on redirect. |
// | Ports       : clk, reset (async, active-low); pcWrite/ifid_writeReg stall  |
// |               controls; branch_taken/branch_target redirect; imem_en/      |
// |               imem_addr/imem_rdata memory port; ifid_* IF/ID register.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage_ctrl
  import pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pcWrite,
  input  logic            ifid_writeReg,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pcPlus4,
  output logic            ifid_valid
);

  localparam ifid_t BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}, 1'b0};

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  ifid_t           ifid_q, ifid_d;

  logic            fetch_en;
  logic            advance;
  logic            hold_capture, hold_release, hold_flush;
  logic            hold_valid;
  logic [XLEN-1:0] hold_instr, hold_pc;

  // A PC advance without an IF/ID load would create a second outstanding
  // word, so that combination is handled as a plain stall.
  assign advance = pcWrite & ifid_writeReg;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    resp_valid_d = 1'b0;
    resp_pc_d    = resp_pc_q;
    fetch_en     = 1'b0;
    hold_capture = 1'b0;
    hold_release = 1'b0;
    hold_flush   = 1'b0;

    if (branch_taken) begin
      // No read this cycle, so the word in flight is simply never consumed.
      pc_d       = branch_target & ALIGN_MASK;
      hold_flush = 1'b1;
      ifid_d     = BUBBLE;
      state_d    = REDIRECT;
    end else begin
      unique case (state_q)
        RUN: begin
          fetch_en = advance;
          if (ifid_writeReg) begin
            ifid_d = resp_valid_q ? ifid_entry(imem_rdata, resp_pc_q) : BUBBLE;
          end else if (resp_valid_q) begin
            hold_capture = 1'b1;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (ifid_writeReg) begin
            ifid_d       = ifid_entry(hold_instr, hold_pc);
            hold_release = 1'b1;
            fetch_en     = advance;
            state_d      = RUN;
          end
        end
        REDIRECT: begin
          fetch_en = 1'b1;
          ifid_d   = BUBBLE;
          state_d  = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    if (fetch_en) begin
      pc_d         = pc_q + INSTR_BYTES;
      resp_valid_d = 1'b1;
      resp_pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      ifid_q       <= BUBBLE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      ifid_q       <= ifid_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk           (clk),
    .rst_n         (reset),
    .capture       (hold_capture),
    .capture_instr (imem_rdata),
    .capture_pc    (resp_pc_q),
    .release_entry (hold_release),
    .flush         (hold_flush),
    .valid         (hold_valid),
    .instr         (hold_instr),
    .pc            (hold_pc)
  );

  // Strobe is combinational so the first fetch goes out in the first cycle
  // after reset release; gating with reset keeps it low during reset.
  assign imem_en      = fetch_en & reset;
  assign imem_addr    = pc_q;
  assign ifid_instr   = ifid_q.instr;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_pcPlus4 = ifid_q.pcPlus4;
  assign ifid_valid   = ifid_q.valid;

  a_no_advance_while_held: assert property (@(posedge clk) disable iff (!reset)
    !(pcWrite && !ifid_writeReg));

  a_hold_entry_present: assert property (@(posedge clk) disable iff (!reset)
    (state_q == HOLD) |-> hold_valid);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_stage_ctrl                                          |
// | Description : Directed self-checking bench for fetch_stage_ctrl. The imem  |
// |               model returns the read address as data (DEADBEEF when idle). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pcWrite = 1'b1;
  logic        ifid_writeReg = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pcPlus4;
  logic        ifid_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  int reads_c      = 0;
  int reads_100    = 0;

  fetch_stage_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset_n),
    .pcWrite       (pcWrite),
    .ifid_writeReg (ifid_writeReg),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pcPlus4  (ifid_pcPlus4),
    .ifid_valid    (ifid_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) begin
      imem_rdata <= imem_addr;
      if (imem_addr == 32'h0000_000C) reads_c <= reads_c + 1;
      if (imem_addr[31:8] == 24'h00_0001) reads_100 <= reads_100 + 1;
    end else begin
      imem_rdata <= 32'hDEAD_BEEF;
    end
  end

  // Apply one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input logic pw, input logic wr, input logic bt, input logic [31:0] tgt);
    @(negedge clk);
    pcWrite       = pw;
    ifid_writeReg = wr;
    branch_taken  = bt;
    branch_target = tgt;
    #1;
  endtask

  // Leaves the bench in cycle 0 after release (first fetch of address 0).
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pcWrite = 1'b1; ifid_writeReg = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pcWrite = 1'b1; ifid_writeReg = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    #1;
    tests_run++;
    if ({imem_en, imem_addr} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_fetch: got en=%b addr=%h, expected en=0 addr=00000000", imem_en, imem_addr);
    end
    tests_run++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pcPlus4} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_ifid: got v=%b instr=%h pc=%h pc4=%h, expected v=0 instr=%h pc=0 pc4=0",
               ifid_valid, ifid_instr, ifid_pc, ifid_pcPlus4, NOP);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests_run++;
    if ({imem_en, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_release: got en=%b addr=%h v=%b, expected en=1 addr=00000000 v=0",
               imem_en, imem_addr, ifid_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pc_exp;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if ({imem_en, imem_addr} !== {1'b1, 32'(4 * k)}) begin
        tests_failed++;
        $display("FAIL stream_fetch cyc%0d: got en=%b addr=%h, expected en=1 addr=%h", k, imem_en, imem_addr, 32'(4 * k));
      end
      pc_exp = 32'(4 * (k - 2));
      tests_run++;
      if (k < 2 ? ({ifid_valid, ifid_instr} !== {1'b0, NOP})
                : ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, pc_exp, pc_exp, pc_exp + 32'd4})) begin
        tests_failed++;
        $display("FAIL stream_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 k, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, k >= 2, pc_exp);
      end
    end
  endtask

  task automatic test_stall_1();
    logic        st [7];
    logic        ee [7];
    logic [31:0] ea [7];
    logic        ev [7];
    logic [31:0] ep [7];
    st = '{1, 1, 0, 1, 1, 1, 1};
    ee = '{1, 1, 0, 1, 1, 1, 1};
    ea = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd16, 32'd20, 32'd24};
    ev = '{0, 1, 1, 1, 1, 1, 1};
    ep = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd12, 32'd16};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      drive(st[c], st[c], 1'b0, 32'h0);
      tests_run++;
      if ({imem_en, imem_addr} !== {ee[c], ea[c]}) begin
        tests_failed++;
        $display("FAIL stall1_fetch cyc%0d: got en=%b addr=%h, expected en=%b addr=%h", c + 1, imem_en, imem_addr, ee[c], ea[c]);
      end
      tests_run++;
      if (ev[c] ? ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, ep[c], ep[c], ep[c] + 32'd4})
                : ({ifid_valid, ifid_instr} !== {1'b0, NOP})) begin
        tests_failed++;
        $display("FAIL stall1_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 c + 1, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, ev[c], ep[c]);
      end
    end
  endtask

  task automatic test_stall_3();
    logic        st [9];
    logic [31:0] ea [9];
    logic        ev [9];
    logic [31:0] ep [9];
    int          base;
    st = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    ea = '{32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12, 32'd16, 32'd20, 32'd24};
    ev = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    ep = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8, 32'd12, 32'd16};
    do_reset();
    base = reads_c;
    for (int c = 0; c < 9; c++) begin
      drive(st[c], st[c], 1'b0, 32'h0);
      tests_run++;
      if ({imem_en, imem_addr} !== {st[c], ea[c]}) begin
        tests_failed++;
        $display("FAIL stall3_fetch cyc%0d: got en=%b addr=%h, expected en=%b addr=%h", c + 1, imem_en, imem_addr, st[c], ea[c]);
      end
      tests_run++;
      if (ev[c] ? ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, ep[c], ep[c], ep[c] + 32'd4})
                : ({ifid_valid, ifid_instr} !== {1'b0, NOP})) begin
        tests_failed++;
        $display("FAIL stall3_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 c + 1, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, ev[c], ep[c]);
      end
    end
    tests_run++;
    if (reads_c - base !== 1) begin
      tests_failed++;
      $display("FAIL stall3_reads_of_12: got %0d, expected 1", reads_c - base);
    end
  endtask

  task automatic test_branch_in_stall();
    logic        st [8];
    logic        bt [8];
    logic        ee [8];
    logic [31:0] ea [8];
    logic        ev [8];
    logic [31:0] ep [8];
    st = '{1, 1, 0, 0, 1, 1, 1, 1};
    bt = '{0, 0, 0, 1, 0, 0, 0, 0};
    ee = '{1, 1, 0, 0, 1, 1, 1, 1};
    ea = '{32'd4, 32'd8, 32'd12, 32'd12, 32'h100, 32'h104, 32'h108, 32'h10C};
    ev = '{0, 1, 1, 1, 0, 0, 1, 1};
    ep = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd0, 32'd0, 32'h100, 32'h104};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(st[c], st[c], bt[c], 32'h0000_0100);
      tests_run++;
      if ({imem_en, imem_addr} !== {ee[c], ea[c]}) begin
        tests_failed++;
        $display("FAIL brstall_fetch cyc%0d: got en=%b addr=%h, expected en=%b addr=%h", c + 1, imem_en, imem_addr, ee[c], ea[c]);
      end
      tests_run++;
      if (ev[c] ? ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, ep[c], ep[c], ep[c] + 32'd4})
                : ({ifid_valid, ifid_instr} !== {1'b0, NOP})) begin
        tests_failed++;
        $display("FAIL brstall_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 c + 1, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, ev[c], ep[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        bt  [8];
    logic [31:0] tgt [8];
    logic        ee  [8];
    logic [31:0] ea  [8];
    logic        ev  [8];
    logic [31:0] ep  [8];
    int          base;
    bt  = '{0, 0, 1, 1, 0, 0, 0, 0};
    tgt = '{32'h0, 32'h0, 32'h100, 32'h202, 32'h0, 32'h0, 32'h0, 32'h0};
    ee  = '{1, 1, 0, 0, 1, 1, 1, 1};
    ea  = '{32'd4, 32'd8, 32'd12, 32'h100, 32'h200, 32'h204, 32'h208, 32'h20C};
    ev  = '{0, 1, 1, 0, 0, 0, 1, 1};
    ep  = '{32'd0, 32'd0, 32'd4, 32'd0, 32'd0, 32'd0, 32'h200, 32'h204};
    do_reset();
    base = reads_100;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b1, bt[c], tgt[c]);
      tests_run++;
      if ({imem_en, imem_addr} !== {ee[c], ea[c]}) begin
        tests_failed++;
        $display("FAIL b2b_fetch cyc%0d: got en=%b addr=%h, expected en=%b addr=%h", c + 1, imem_en, imem_addr, ee[c], ea[c]);
      end
      tests_run++;
      if (ev[c] ? ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, ep[c], ep[c], ep[c] + 32'd4})
                : ({ifid_valid, ifid_instr} !== {1'b0, NOP})) begin
        tests_failed++;
        $display("FAIL b2b_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 c + 1, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, ev[c], ep[c]);
      end
    end
    tests_run++;
    if (reads_100 - base !== 0) begin
      tests_failed++;
      $display("FAIL b2b_reads_0x100_page: got %0d, expected 0", reads_100 - base);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic        st [6];
    logic        bt [6];
    logic        ee [6];
    logic [31:0] ea [6];
    logic        ev [6];
    logic [31:0] ep [6];
    st = '{1, 1, 1, 1, 1, 0};
    bt = '{1, 0, 0, 0, 0, 0};
    ee = '{0, 1, 1, 1, 1, 0};
    ea = '{32'd4, 32'hFFFF_FFFC, 32'd0, 32'd4, 32'd8, 32'd12};
    ev = '{0, 0, 0, 1, 1, 1};
    ep = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0, 32'd4};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(st[c], st[c], bt[c], 32'hFFFF_FFFC);
      tests_run++;
      if ({imem_en, imem_addr} !== {ee[c], ea[c]}) begin
        tests_failed++;
        $display("FAIL wrap_fetch cyc%0d: got en=%b addr=%h, expected en=%b addr=%h", c + 1, imem_en, imem_addr, ee[c], ea[c]);
      end
      tests_run++;
      if (ev[c] ? ({ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4} !== {1'b1, ep[c], ep[c], ep[c] + 32'd4})
                : ({ifid_valid, ifid_instr} !== {1'b0, NOP})) begin
        tests_failed++;
        $display("FAIL wrap_ifid cyc%0d: got v=%b pc=%h instr=%h pc4=%h, expected v=%b pc=%h",
                 c + 1, ifid_valid, ifid_pc, ifid_instr, ifid_pcPlus4, ev[c], ep[c]);
      end
      if (c == 3) begin
        tests_run++;
        if (ifid_pcPlus4 !== 32'h0) begin
          tests_failed++;
          $display("FAIL wrap_pcplus4: got %h, expected 00000000", ifid_pcPlus4);
        end
      end
    end
    // Second stall cycle (hold buffer occupied), reset asserted mid-cycle.
    @(negedge clk);
    pcWrite = 1'b0; ifid_writeReg = 1'b0;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({imem_en, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pcPlus4} !==
        {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL midreset: got en=%b addr=%h v=%b instr=%h pc=%h pc4=%h, expected en=0 addr=0 v=0 instr=%h pc=0 pc4=0",
               imem_en, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pcPlus4, NOP);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; pcWrite = 1'b1; ifid_writeReg = 1'b1;
    #1;
    tests_run++;
    if ({imem_en, imem_addr, ifid_valid} !== {1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_release: got en=%b addr=%h v=%b, expected en=1 addr=0 v=0", imem_en, imem_addr, ifid_valid);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL midreset_restart: got v=%b pc=%h instr=%h, expected v=1 pc=0 instr=0", ifid_valid, ifid_pc, ifid_instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall_1();
    test_stall_3();
    test_branch_in_stall();
    test_back_to_back();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
